// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between instruction memory and the IF/ID register
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0001_0000,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         br_early_valid,
    input  logic [31:0]                  br_early_pc,
    input  logic                         br_late_valid,
    input  logic [31:0]                  br_late_pc,
    output logic [31:0]                  iaddr,
    input  logic                         iready_n,
    input  logic [31:0]                  idata,
    output logic                         inst_valid,
    output logic [31:0]                  inst,
    output logic [31:0]                  inst_pc,
    output logic [31:0]                  inst_pcp4,
    output logic [4:0]                   rs1_early,
    output logic [4:0]                   rs2_early,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic        flush;
    logic [31:0] target;
    logic        push;
    logic        pop;

    // Late redirect wins: EX holds the older instruction
    assign flush  = br_late_valid | br_early_valid;
    assign target = br_late_valid ? br_late_pc : br_early_pc;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = !iready_n && !full && !flush;
    assign pop   = !stall && !empty && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            iaddr  <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            iaddr  <= target;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                iaddr  <= iaddr + 32'd4;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry contents are don't-care after reset, so storage carries no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= iaddr;
            mem_inst[wr_ptr] <= idata;
        end
    end

    always_comb begin
        inst_valid = !empty;
        inst       = BUBBLE;
        inst_pc    = 32'd0;
        if (!empty) begin
            inst    = mem_inst[rd_ptr];
            inst_pc = mem_pc[rd_ptr];
        end
        inst_pcp4 = inst_pc + 32'd4;
        rs1_early = inst[19:15];
        rs2_early = inst[24:20];
    end

endmodule
